// File: rtl/rob_ring.sv
// -----------------------------------------------------------------------------
// rob_ring
//
// Reorder buffer built as a circular queue. Dispatch allocates entries in
// program order at the tail. Execution units write results back out of order
// on WB_PORTS channels, addressed by entry tag. Completed entries retire
// strictly in order from the head, at most one per cycle, onto a registered
// commit port. The commit port feeds the register file and reservation
// stations. A synchronous flush discards every entry for mispredict recovery.
//
// Parameters
//   DEPTH    number of entries (power of two, >= 2)
//   DATA_W   result data width
//   NAME_W   destination register name width (name 0 = no destination)
//   WB_PORTS number of writeback channels
//   TAG_W    entry index width, derived from DEPTH
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   flush         synchronous discard of all entries
//   alloc_valid   dispatch requests an entry
//   alloc_name    destination register of the allocated instruction
//   alloc_ready   an entry is free (count != DEPTH)
//   alloc_tag     index the next allocation receives (tail pointer)
//   wb_valid      per-channel result valid
//   wb_tag        per-channel target entry, channel k at [k*TAG_W +: TAG_W]
//   wb_data       per-channel result, channel k at [k*DATA_W +: DATA_W]
//   commit_valid  registered: one entry retired this cycle
//   commit_name   registered destination of the retired entry
//   commit_tag    registered index of the retired entry
//   commit_data   registered result of the retired entry
//   count         occupied entries, 0..DEPTH
//   empty         count == 0
// -----------------------------------------------------------------------------
module rob_ring #(
  parameter  int DEPTH    = 16,
  parameter  int DATA_W   = 32,
  parameter  int NAME_W   = 5,
  parameter  int WB_PORTS = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic [NAME_W-1:0]            alloc_name,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  output logic                         commit_valid,
  output logic [NAME_W-1:0]            commit_name,
  output logic [TAG_W-1:0]             commit_tag,
  output logic [DATA_W-1:0]            commit_data,
  output logic [TAG_W:0]               count,
  output logic                         empty
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  // Per-entry state
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [NAME_W-1:0] name_q [DEPTH];
  logic [NAME_W-1:0] name_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Ring pointers and occupancy
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Registered commit port
  logic              commit_valid_q, commit_valid_d;
  logic [NAME_W-1:0] commit_name_q, commit_name_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;

  // Unpacked writeback channels
  logic [TAG_W-1:0]  wb_tag_s  [WB_PORTS];
  logic [DATA_W-1:0] wb_data_s [WB_PORTS];

  logic alloc_fire_s;
  logic commit_fire_s;

  // Split the packed writeback buses into per-channel fields
  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wb_tag_s[k]  = wb_tag[k*TAG_W +: TAG_W];
      wb_data_s[k] = wb_data[k*DATA_W +: DATA_W];
    end
  end

  // Readiness depends only on registered count. A commit in the same cycle
  // does not reopen a full ring until the following cycle.
  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_tag   = tail_q;
  assign empty       = (count_q == {(TAG_W+1){1'b0}});

  // Flush suppresses every state-changing event in its cycle
  assign alloc_fire_s  = alloc_valid & alloc_ready & ~flush;
  assign commit_fire_s = busy_q[head_q] & done_q[head_q] & ~flush;

  // Entry next-state: writeback, then retire at head, then allocate at tail
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    for (int i = 0; i < DEPTH; i++) begin
      name_d[i] = name_q[i];
      data_d[i] = data_q[i];
    end

    if (flush) begin
      busy_d = {DEPTH{1'b0}};
      done_d = {DEPTH{1'b0}};
    end else begin
      // Ascending channel order lets the highest channel win a tag collision.
      // Only busy_q is consulted, so an entry allocated this cycle cannot
      // take a result until the next cycle.
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && busy_q[wb_tag_s[k]]) begin
          done_d[wb_tag_s[k]] = 1'b1;
          data_d[wb_tag_s[k]] = wb_data_s[k];
        end else begin
          done_d[wb_tag_s[k]] = done_d[wb_tag_s[k]];
        end
      end

      if (commit_fire_s) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
      end else begin
        busy_d[head_q] = busy_d[head_q];
      end

      // The tail entry is free whenever alloc fires, so the retire above
      // never lands on the same slot.
      if (alloc_fire_s) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        name_d[tail_q] = alloc_name;
      end else begin
        busy_d[tail_q] = busy_d[tail_q];
      end
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      head_d  = {TAG_W{1'b0}};
      tail_d  = {TAG_W{1'b0}};
      count_d = {(TAG_W+1){1'b0}};
    end else begin
      if (commit_fire_s) begin
        head_d = head_q + TAG_ONE;
      end else begin
        head_d = head_q;
      end

      if (alloc_fire_s) begin
        tail_d = tail_q + TAG_ONE;
      end else begin
        tail_d = tail_q;
      end

      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Commit port next-state; payload holds its value on idle cycles
  always_comb begin
    commit_valid_d = 1'b0;
    commit_name_d  = commit_name_q;
    commit_tag_d   = commit_tag_q;
    commit_data_d  = commit_data_q;

    if (commit_fire_s) begin
      commit_valid_d = 1'b1;
      commit_name_d  = name_q[head_q];
      commit_tag_d   = head_q;
      commit_data_d  = data_q[head_q];
    end else begin
      commit_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= {DEPTH{1'b0}};
      done_q         <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        name_q[i] <= {NAME_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
      head_q         <= {TAG_W{1'b0}};
      tail_q         <= {TAG_W{1'b0}};
      count_q        <= {(TAG_W+1){1'b0}};
      commit_valid_q <= 1'b0;
      commit_name_q  <= {NAME_W{1'b0}};
      commit_tag_q   <= {TAG_W{1'b0}};
      commit_data_q  <= {DATA_W{1'b0}};
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        name_q[i] <= name_d[i];
        data_q[i] <= data_d[i];
      end
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_name_q  <= commit_name_d;
      commit_tag_q   <= commit_tag_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_name  = commit_name_q;
  assign commit_tag   = commit_tag_q;
  assign commit_data  = commit_data_q;
  assign count        = count_q;

endmodule

// File: tb/tb_rob_ring.sv
// -----------------------------------------------------------------------------
// tb_rob_ring
//
// Directed bench for rob_ring. The reference model keeps the buffer contents
// as a program-ordered queue of in-flight instructions. Every falling edge
// advances the model by the cycle that just ended and compares all outputs.
// Literal checks at chosen points pin the expected commit sequence and the
// boundary cases.
// -----------------------------------------------------------------------------
module tb_rob_ring;

  localparam int DEPTH    = 16;
  localparam int DATA_W   = 32;
  localparam int NAME_W   = 5;
  localparam int WB_PORTS = 2;
  localparam int TAG_W    = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       alloc_valid;
  logic [NAME_W-1:0]          alloc_name;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*TAG_W-1:0]  wb_tag;
  logic [WB_PORTS*DATA_W-1:0] wb_data;
  logic                       commit_valid;
  logic [NAME_W-1:0]          commit_name;
  logic [TAG_W-1:0]           commit_tag;
  logic [DATA_W-1:0]          commit_data;
  logic [TAG_W:0]             count;
  logic                       empty;

  rob_ring #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .NAME_W  (NAME_W),
    .WB_PORTS(WB_PORTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_name  (alloc_name),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .commit_valid(commit_valid),
    .commit_name (commit_name),
    .commit_tag  (commit_tag),
    .commit_data (commit_data),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [NAME_W-1:0] name;
    bit                done;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [NAME_W-1:0] name;
    logic [DATA_W-1:0] data;
  } cmt_t;

  ent_t              mq[$];     // in-flight instructions, oldest first
  logic [TAG_W-1:0]  m_tail;
  logic              m_cv;
  logic [NAME_W-1:0] m_cname;
  logic [TAG_W-1:0]  m_ctag;
  logic [DATA_W-1:0] m_cdata;
  cmt_t              log_q[$];  // commits seen on the DUT port

  task automatic model_reset();
    mq.delete();
    m_tail  = '0;
    m_cv    = 1'b0;
    m_cname = '0;
    m_ctag  = '0;
    m_cdata = '0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle
  task automatic model_step();
    bit   fire_a;
    bit   fire_c;
    ent_t e;
    if (flush) begin
      mq.delete();
      m_tail = '0;
      m_cv   = 1'b0;
    end else begin
      fire_c = (mq.size() > 0) && mq[0].done;
      fire_a = alloc_valid && (mq.size() < DEPTH);
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k]) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == wb_tag[k*TAG_W +: TAG_W]) begin
              e      = mq[i];
              e.done = 1'b1;
              e.data = wb_data[k*DATA_W +: DATA_W];
              mq[i]  = e;
            end
          end
        end
      end
      if (fire_c) begin
        m_cv    = 1'b1;
        m_cname = mq[0].name;
        m_ctag  = mq[0].tag;
        m_cdata = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_cv = 1'b0;
      end
      if (fire_a) begin
        e.tag  = m_tail;
        e.name = alloc_name;
        e.done = 1'b0;
        e.data = '0;
        mq.push_back(e);
        m_tail = m_tail + 4'd1;
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    cmt_t c;
    if (rst) begin
      model_reset();
    end else begin
      model_step();
      check("alloc_ready",  alloc_ready,  mq.size() != DEPTH);
      check("alloc_tag",    alloc_tag,    m_tail);
      check("count",        count,        mq.size());
      check("empty",        empty,        mq.size() == 0);
      check("commit_valid", commit_valid, m_cv);
      check("commit_name",  commit_name,  m_cname);
      check("commit_tag",   commit_tag,   m_ctag);
      check("commit_data",  commit_data,  m_cdata);
      if (commit_valid === 1'b1) begin
        c.tag  = commit_tag;
        c.name = commit_name;
        c.data = commit_data;
        log_q.push_back(c);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 1 time unit after the falling edge and hold for the next
  // rising edge. On return, outputs reflect every earlier drive() call.
  task automatic drive(input logic av, input logic [NAME_W-1:0] an,
                       input logic [1:0] wv,
                       input logic [TAG_W-1:0] t0, input logic [DATA_W-1:0] d0,
                       input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                       input logic fl);
    @(negedge clk);
    #1;
    alloc_valid = av;
    alloc_name  = an;
    wb_valid    = wv;
    wb_tag      = {t1, t0};
    wb_data     = {d1, d0};
    flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic alloc(input logic [NAME_W-1:0] n);
    drive(1'b1, n, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic wb0(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    drive(1'b0, 5'd0, 2'b01, t, d, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_commit_valid"}, commit_valid, 1'b0);
    check({pfx, "_commit_name"},  commit_name,  5'd0);
    check({pfx, "_commit_tag"},   commit_tag,   4'd0);
    check({pfx, "_commit_data"},  commit_data,  32'd0);
    check({pfx, "_count"},        count,        5'd0);
    check({pfx, "_empty"},        empty,        1'b1);
    check({pfx, "_alloc_ready"},  alloc_ready,  1'b1);
    check({pfx, "_alloc_tag"},    alloc_tag,    4'd0);
  endtask

  // Assert reset between clock edges and check that it acts at once
  task automatic do_reset();
    @(negedge clk);
    #1;
    alloc_valid = 1'b0;
    wb_valid    = 2'b00;
    flush       = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_name  = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_data     = '0;
    #3;
    check_reset_values("por");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // In-order retire of out-of-order results
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    wb0(4'd2, 32'hC);
    wb0(4'd0, 32'hA);
    check("inorder_no_early_commit", log_q.size(), 0);
    wb0(4'd1, 32'hB);
    check("inorder_wb_to_commit_latency", log_q.size(), 0);
    repeat (4) idle();
    check("inorder_n",     log_q.size(), 3);
    check("inorder_t0",    log_q[0].tag,  4'd0);
    check("inorder_d0",    log_q[0].data, 32'hA);
    check("inorder_n0",    log_q[0].name, 5'd1);
    check("inorder_t1",    log_q[1].tag,  4'd1);
    check("inorder_d1",    log_q[1].data, 32'hB);
    check("inorder_t2",    log_q[2].tag,  4'd2);
    check("inorder_d2",    log_q[2].data, 32'hC);
    check("inorder_count", count, 5'd0);

    // Mid-operation reset with entries pending, then fill the ring
    alloc(5'd7);
    alloc(5'd8);
    idle();
    check("pre_rst_count", count, 5'd2);
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1));
    idle();
    check("full_count", count, 5'd16);
    check("full_ready", alloc_ready, 1'b0);
    alloc(5'd20);
    idle();
    check("full_17th_ignored", count, 5'd16);
    check("full_tail_wrap", alloc_tag, 4'd0);
    wb0(4'd0, 32'h100);
    alloc(5'd21);
    check("full_ready_before_commit", alloc_ready, 1'b0);
    idle();
    check("full_commit_valid", commit_valid, 1'b1);
    check("full_commit_data", commit_data, 32'h100);
    check("full_count_after", count, 5'd15);
    check("full_ready_after", alloc_ready, 1'b1);
    check("full_next_tag", alloc_tag, 4'd0);
    alloc(5'd22);
    idle();
    check("full_refill_count", count, 5'd16);
    check("full_refill_tag", alloc_tag, 4'd1);

    // Dual writeback and same-tag collision
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1));
    wb0(4'd0, 32'h10);
    wb0(4'd1, 32'h11);
    wb0(4'd2, 32'h12);
    drive(1'b0, 5'd0, 2'b11, 4'd3, 32'h33, 4'd4, 32'h44, 1'b0);
    alloc(5'd6);
    drive(1'b0, 5'd0, 2'b11, 4'd5, 32'h55, 4'd5, 32'h66, 1'b0);
    repeat (4) idle();
    check("dual_n",  log_q.size(), 6);
    check("dual_t3", log_q[3].tag,  4'd3);
    check("dual_d3", log_q[3].data, 32'h33);
    check("dual_t4", log_q[4].tag,  4'd4);
    check("dual_d4", log_q[4].data, 32'h44);
    check("dual_same_tag_ch1_wins", log_q[5].data, 32'h66);

    // Flush with simultaneous alloc and writeback
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1));
    wb0(4'd0, 32'h20);
    drive(1'b1, 5'd9, 2'b01, 4'd1, 32'hDEAD, 4'd0, 32'd0, 1'b1);
    idle();
    check("flush_count", count, 5'd0);
    check("flush_empty", empty, 1'b1);
    check("flush_commit_valid", commit_valid, 1'b0);
    check("flush_alloc_tag", alloc_tag, 4'd0);
    log_q.delete();
    for (int i = 0; i < 5; i++) wb0(4'(i), 32'h70 + 32'(i));
    alloc(5'd3);
    repeat (3) idle();
    check("flush_old_wb_ignored", log_q.size(), 0);
    check("flush_realloc_count", count, 5'd1);

    // Simultaneous alloc and commit at count 8
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    wb0(4'd0, 32'h80);
    alloc(5'd9);
    check("ac_count_before", count, 5'd8);
    idle();
    check("ac_count", count, 5'd8);
    check("ac_tail", alloc_tag, 4'd9);
    check("ac_commit_valid", commit_valid, 1'b1);
    check("ac_commit_tag", commit_tag, 4'd0);
    wb0(4'd1, 32'h81);
    idle();
    idle();
    check("ac_head_advanced", commit_tag, 4'd1);
    check("ac_head_data", commit_data, 32'h81);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
